// File: rtl/tilemap_pkg.sv
// Shared constants, request type and address decoder for the tilemap dirty-tile encoder.
package tilemap_pkg;

   localparam logic [9:0] TOP_OFFSET    = 10'h3C2;
   localparam logic [9:0] BOTTOM_OFFSET = 10'h002;
   localparam logic [9:0] MID_OFFSET    = 10'h040;
   localparam logic [9:0] MID_LAST      = 10'h3BF;
   localparam int         TOTAL_ROWS    = 36;
   localparam int         TOTAL_COLS    = 28;

   localparam logic [9:0] COL_MAX10 = 10'(TOTAL_COLS - 1);
   localparam logic [5:0] ROW_LAST  = 6'(TOTAL_ROWS - 1);
   localparam logic [4:0] COL_LAST  = 5'(TOTAL_COLS - 1);

   // Border bands: the two top rows and the two bottom rows, each 28 words long.
   localparam logic [9:0] EDGE_BASE [4] = '{TOP_OFFSET, TOP_OFFSET + 10'h020,
                                            BOTTOM_OFFSET, BOTTOM_OFFSET + 10'h020};
   localparam logic [5:0] EDGE_ROW  [4] = '{6'd0, 6'd1, 6'd34, 6'd35};

   typedef struct packed {
      logic [5:0] row;
      logic [4:0] col;
   } tile_req_t;

   typedef struct packed {
      logic      mapped;
      tile_req_t req;
   } dec_t;

   typedef enum logic {ST_IDLE = 1'b0, ST_SWEEP = 1'b1} sweep_state_t;

   function automatic dec_t decode_addr(input logic [9:0] addr);
      dec_t       d;
      logic [9:0] off;
      d   = '0;
      off = '0;
      if (addr >= MID_OFFSET && addr <= MID_LAST) begin
         // Playfield is column-major with the screen mirrored horizontally.
         off        = addr - MID_OFFSET;
         d.mapped   = 1'b1;
         d.req.row  = {1'b0, off[4:0]} + 6'd2;
         d.req.col  = 5'(COL_MAX10 - {5'b0, off[9:5]});
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (addr >= EDGE_BASE[b] && addr <= EDGE_BASE[b] + COL_MAX10) begin
               off       = addr - EDGE_BASE[b];
               d.mapped  = 1'b1;
               d.req.row = EDGE_ROW[b];
               d.req.col = 5'(COL_MAX10 - off);
            end
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/tilemap_req_fifo.sv
// Show-ahead request FIFO; a push while full is accepted only if a pop frees a slot.
module tilemap_req_fifo
   import tilemap_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic      clk,
   input  logic      rst_l,
   input  logic      i_push,
   input  tile_req_t i_data,
   input  logic      i_pop,
   output tile_req_t o_data,
   output logic      o_full,
   output logic      o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   tile_req_t   r_mem [DEPTH];
   logic        w_push_ok;
   logic        w_pop_ok;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | w_pop_ok);
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/tilemap_dirty_enc.sv
// Maps tile-RAM writes to screen tiles, queues redraw requests and runs full-screen sweeps.
module tilemap_dirty_enc
   import tilemap_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             wr_en,
   input  logic [9:0]       wr_addr,
   input  logic             refresh_req,
   input  logic             clr_status,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [5:0]       out_tile_row,
   output logic [4:0]       out_tile_col,
   output logic [8:0]       out_px_row,
   output logic [9:0]       out_px_col,
   output logic             out_sweep,
   output logic             busy,
   output logic             overflow,
   output logic [CNT_W-1:0] drop_cnt
);

   dec_t         w_dec;
   logic         r_s1_valid;
   tile_req_t    r_s1_req;
   tile_req_t    w_fifo_head;
   logic         w_fifo_full;
   logic         w_fifo_empty;
   logic         w_fifo_pop;
   logic         w_ovf_ev;
   logic         w_drop_ev;
   sweep_state_t r_state, w_state_nxt;
   logic [5:0]   r_row, w_row_nxt;
   logic [4:0]   r_col, w_col_nxt;
   logic         r_pend, w_pend_nxt;
   tile_req_t    w_out;

   assign w_dec      = decode_addr(wr_addr);
   assign busy       = (r_state == ST_SWEEP);
   assign w_fifo_pop = out_ready & ~busy & ~w_fifo_empty;
   assign w_ovf_ev   = r_s1_valid & w_fifo_full & ~w_fifo_pop;
   assign w_drop_ev  = wr_en & ~w_dec.mapped;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_s1_valid <= 1'b0;
         r_s1_req   <= '0;
      end else begin
         r_s1_valid <= wr_en & w_dec.mapped;
         if (wr_en) r_s1_req <= w_dec.req;
      end
   end

   tilemap_req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_l   (rst_l),
      .i_push  (r_s1_valid),
      .i_data  (r_s1_req),
      .i_pop   (w_fifo_pop),
      .o_data  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (w_ovf_ev)        overflow <= 1'b1;
         else if (clr_status) overflow <= 1'b0;
         if (w_drop_ev) begin
            if (clr_status)          drop_cnt <= CNT_W'(1);
            else if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
         end else if (clr_status) begin
            drop_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_state <= ST_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_col   <= w_col_nxt;
         r_pend  <= w_pend_nxt;
      end
   end

   // A sweep request that arrives while a FIFO entry is stalled is held until
   // the stall clears, so the presented request never changes mid-handshake.
   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_pend_nxt  = r_pend;
      case (r_state)
         ST_IDLE: begin
            if ((refresh_req | r_pend) & ~(~w_fifo_empty & ~out_ready)) begin
               w_state_nxt = ST_SWEEP;
               w_row_nxt   = '0;
               w_col_nxt   = '0;
               w_pend_nxt  = 1'b0;
            end else if (refresh_req) begin
               w_pend_nxt  = 1'b1;
            end
         end
         ST_SWEEP: begin
            if (out_ready) begin
               if (r_col == COL_LAST) begin
                  w_col_nxt = '0;
                  if (r_row == ROW_LAST) w_state_nxt = ST_IDLE;
                  else                   w_row_nxt   = r_row + 6'd1;
               end else begin
                  w_col_nxt = r_col + 5'd1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_out = '0;
      if (busy)               w_out = '{row: r_row, col: r_col};
      else if (!w_fifo_empty) w_out = w_fifo_head;
      out_valid    = busy | ~w_fifo_empty;
      out_sweep    = busy;
      out_tile_row = w_out.row;
      out_tile_col = w_out.col;
      out_px_row   = {w_out.row, 3'b000};
      out_px_col   = {2'b00, w_out.col, 3'b000};
   end

endmodule

// File: tb/tb_tilemap_dirty_enc.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_tilemap_dirty_enc;

   localparam int DEPTH = 8;
   localparam int CNT_W = 8;
   localparam int N_TILES = 36 * 28;

   logic             clk = 1'b0;
   logic             rst_l = 1'b0;
   logic             wr_en = 1'b0;
   logic [9:0]       wr_addr = '0;
   logic             refresh_req = 1'b0;
   logic             clr_status = 1'b0;
   logic             out_ready = 1'b0;
   logic             out_valid;
   logic [5:0]       out_tile_row;
   logic [4:0]       out_tile_col;
   logic [8:0]       out_px_row;
   logic [9:0]       out_px_col;
   logic             out_sweep;
   logic             busy;
   logic             overflow;
   logic [CNT_W-1:0] drop_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   tilemap_dirty_enc #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .refresh_req  (refresh_req),
      .clr_status   (clr_status),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_tile_row (out_tile_row),
      .out_tile_col (out_tile_col),
      .out_px_row   (out_px_row),
      .out_px_col   (out_px_col),
      .out_sweep    (out_sweep),
      .busy         (busy),
      .overflow     (overflow),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {int row; int col;} req_t;

   req_t m_q[$];
   bit   m_busy = 0;
   int   m_k = 0;
   bit   m_pend = 0;
   bit   m_s1_v = 0;
   req_t m_s1_r = '{0, 0};
   bit   m_ovf = 0;
   int   m_drop = 0;

   function automatic void ref_decode(input int a, output bit m, output req_t r);
      m = 1;
      r = '{0, 0};
      if (a >= 'h040 && a <= 'h3BF)      r = '{2 + (a - 'h040) % 32, 27 - (a - 'h040) / 32};
      else if (a >= 'h3C2 && a <= 'h3DD) r = '{0, 27 - (a - 'h3C2)};
      else if (a >= 'h3E2 && a <= 'h3FD) r = '{1, 27 - (a - 'h3E2)};
      else if (a >= 'h002 && a <= 'h01D) r = '{34, 27 - (a - 'h002)};
      else if (a >= 'h022 && a <= 'h03D) r = '{35, 27 - (a - 'h022)};
      else m = 0;
   endfunction

   function void model_out(output bit v, output req_t r, output bit sw);
      v  = m_busy || (m_q.size() > 0);
      sw = m_busy;
      r  = '{0, 0};
      if (m_busy)               r = '{m_k / 28, m_k % 28};
      else if (m_q.size() > 0)  r = m_q[0];
   endfunction

   always @(posedge clk or negedge rst_l) begin
      bit   v, sw, xfer, pop, ovf_ev, mapped;
      req_t r, d;
      if (!rst_l) begin
         m_q.delete();
         m_busy = 0; m_k = 0; m_pend = 0; m_s1_v = 0; m_ovf = 0; m_drop = 0;
      end else begin
         model_out(v, r, sw);
         xfer   = v && out_ready;
         pop    = xfer && !m_busy;
         ovf_ev = m_s1_v && (m_q.size() == DEPTH) && !pop;
         if (pop) void'(m_q.pop_front());
         if (m_s1_v && !ovf_ev) m_q.push_back(m_s1_r);
         ref_decode(int'(wr_addr), mapped, d);
         m_s1_v = wr_en && mapped;
         m_s1_r = d;
         if (ovf_ev)          m_ovf = 1;
         else if (clr_status) m_ovf = 0;
         if (wr_en && !mapped) m_drop = clr_status ? 1 : (m_drop == 255 ? 255 : m_drop + 1);
         else if (clr_status)  m_drop = 0;
         if (m_busy) begin
            if (xfer) begin
               if (m_k == N_TILES - 1) m_busy = 0;
               else                    m_k++;
            end
         end else if ((refresh_req || m_pend) && !(v && !out_ready)) begin
            m_busy = 1; m_k = 0; m_pend = 0;
         end else if (refresh_req) begin
            m_pend = 1;
         end
      end
   end

   always @(negedge clk) begin
      bit   v, sw;
      req_t r;
      if (rst_l) begin
         model_out(v, r, sw);
         check("valid", 32'(out_valid), 32'(v));
         check("busy", 32'(busy), 32'(m_busy));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
         if (v) begin
            check("tile_row", 32'(out_tile_row), 32'(r.row));
            check("tile_col", 32'(out_tile_col), 32'(r.col));
            check("px_row", 32'(out_px_row), 32'(r.row * 8));
            check("px_col", 32'(out_px_col), 32'(r.col * 8));
            check("sweep", 32'(out_sweep), 32'(sw));
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_req(input string name, input int row, input int col,
                             input int pxr, input int pxc, input bit sw);
      check({name, "_valid"}, 32'(out_valid), 32'd1);
      check({name, "_row"}, 32'(out_tile_row), 32'(row));
      check({name, "_col"}, 32'(out_tile_col), 32'(col));
      check({name, "_pxr"}, 32'(out_px_row), 32'(pxr));
      check({name, "_pxc"}, 32'(out_px_col), 32'(pxc));
      check({name, "_sweep"}, 32'(out_sweep), 32'(sw));
   endtask

   int edge_addrs [10] = '{'h040, 'h3BF, 'h3C2, 'h3DD, 'h3E2, 'h3FD, 'h002, 'h01D, 'h022, 'h03D};
   int unmapped [16]   = '{'h000, 'h001, 'h01E, 'h01F, 'h020, 'h021, 'h03E, 'h03F,
                           'h3C0, 'h3C1, 'h3DE, 'h3DF, 'h3E0, 'h3E1, 'h3FE, 'h3FF};

   initial begin
      int t2_addr [4]  = '{'h3C2, 'h3FD, 'h002, 'h03D};
      int t2_row  [4]  = '{0, 1, 34, 35};
      int t2_col  [4]  = '{27, 0, 27, 0};
      int t3_addr [4]  = '{'h000, 'h3FF, 'h3C0, 'h020};
      int got_row [$];
      int got_col [$];
      int n_sw, last_r, last_c, fifo_r, fifo_c;
      bit done;

      repeat (3) tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      check("rst_row", 32'(out_tile_row), 32'd0);
      check("rst_pxc", 32'(out_px_col), 32'd0);
      rst_l = 1'b1;
      tick();

      // 1: two-cycle latency, playfield corners
      out_ready = 1'b1;
      wr_en = 1'b1; wr_addr = 10'h040; tick();
      check("t1_lat", 32'(out_valid), 32'd0);
      wr_addr = 10'h3BF; tick();
      wr_en = 1'b0;
      expect_req("t1_a", 2, 27, 16, 216, 0);
      tick();
      expect_req("t1_b", 33, 0, 264, 0, 0);
      tick();
      check("t1_empty", 32'(out_valid), 32'd0);

      // 2: border bands, in write order
      for (int i = 0; i < 6; i++) begin
         if (i >= 2) expect_req("t2", t2_row[i-2], t2_col[i-2], t2_row[i-2] * 8, t2_col[i-2] * 8, 0);
         if (i < 4) begin wr_en = 1'b1; wr_addr = 10'(t2_addr[i]); end
         else       wr_en = 1'b0;
         tick();
      end

      // 3: unmapped writes only count
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_addr = 10'(t3_addr[i]); tick();
      end
      wr_en = 1'b0;
      check("t3_drop", 32'(drop_cnt), 32'd4);
      tick();
      check("t3_novalid", 32'(out_valid), 32'd0);
      clr_status = 1'b1; tick(); clr_status = 1'b0;
      check("t3_clr", 32'(drop_cnt), 32'd0);

      // 4: overflow with stalled output
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         wr_en = 1'b1; wr_addr = 10'('h040 + i); tick();
      end
      wr_en = 1'b0;
      tick(); tick();
      check("t4_overflow", 32'(overflow), 32'd1);
      out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (out_valid) begin got_row.push_back(int'(out_tile_row)); got_col.push_back(int'(out_tile_col)); end
         tick();
      end
      check("t4_count", 32'(got_row.size()), 32'(DEPTH));
      for (int i = 0; i < got_row.size() && i < DEPTH; i++) begin
         check("t4_row", 32'(got_row[i]), 32'(2 + i));
         check("t4_col", 32'(got_col[i]), 32'd27);
      end
      clr_status = 1'b1; tick(); clr_status = 1'b0;

      // 5: full sweep with a write queued behind it
      refresh_req = 1'b1; tick(); refresh_req = 1'b0;
      n_sw = 0; last_r = -1; last_c = -1; fifo_r = -1; fifo_c = -1; done = 0;
      for (int c = 0; c < 1100 && !done; c++) begin
         wr_en = (c == 2); wr_addr = 10'h040;
         if (out_valid && out_sweep) begin
            n_sw++; last_r = int'(out_tile_row); last_c = int'(out_tile_col);
         end else if (out_valid) begin
            fifo_r = int'(out_tile_row); fifo_c = int'(out_tile_col); done = 1;
            check("t5_busy_fell", 32'(busy), 32'd0);
         end
         if (!done) tick();
      end
      wr_en = 1'b0;
      check("t5_done", 32'(done), 32'd1);
      check("t5_nsweep", 32'(n_sw), 32'(N_TILES));
      check("t5_last_row", 32'(last_r), 32'd35);
      check("t5_last_col", 32'(last_c), 32'd27);
      check("t5_fifo_row", 32'(fifo_r), 32'd2);
      check("t5_fifo_col", 32'(fifo_c), 32'd27);
      tick(); tick();

      // 6: asynchronous reset mid-sweep with queued requests
      out_ready = 1'b0;
      refresh_req = 1'b1; tick(); refresh_req = 1'b0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         wr_en = 1'b1; wr_addr = 10'('h100 + i); tick();
      end
      wr_en = 1'b0;
      tick(); tick();
      check("t6_pre_busy", 32'(busy), 32'd1);
      check("t6_pre_ovf", 32'(overflow), 32'd1);
      #2 rst_l = 1'b0;
      #1;
      check("t6_valid", 32'(out_valid), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_ovf", 32'(overflow), 32'd0);
      tick();
      rst_l = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         check("t6_nostale", 32'(out_valid), 32'd0);
         tick();
      end

      // random traffic against the model
      for (int c = 0; c < 6000; c++) begin
         int sel;
         sel = int'($urandom_range(0, 3));
         wr_en = ($urandom_range(0, 1) == 1);
         if (sel == 0)      wr_addr = 10'(unmapped[$urandom_range(0, 15)]);
         else if (sel == 1) wr_addr = 10'(edge_addrs[$urandom_range(0, 9)]);
         else               wr_addr = 10'($urandom_range(0, 1023));
         out_ready   = ((c / 300) % 3 == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         refresh_req = ($urandom_range(0, 699) == 0);
         clr_status  = ($urandom_range(0, 1499) == 0);
         tick();
      end
      wr_en = 1'b0; refresh_req = 1'b0; clr_status = 1'b0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
